lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store initiator that sits between the execute stage and the data-memory responder.
- Takes one byte/half/word/double access, aligned or unaligned, and issues it as one or two 8-byte-aligned beats on a valid/ready request channel.
- Merges the read beats, then sign- or zero-extends the result.
- Returns the result to the pipeline with a one-cycle completion pulse.

Parameters:
- TIMEOUT, 1024: cycles allowed in any single memory-wait state before the access aborts with an error.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  pipeline access request; held stable until resp_valid
- req_ready  out  1  block idle, can accept
- req_addr  in  64  byte address
- req_memop  in  3  [1:0]: 3=1B, 2=2B, 1=4B, 0=8B; [2]=sign-extend; 3'd0 with req_wen=0 = no-op
- req_wen  in  1  1=store, 0=load
- req_wdata  in  64  store data, LSB-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  64  extended load data; 0 for stores, no-ops and errors
- resp_err  out  1  valid with resp_valid; 1=timeout
- mem_valid  out  1  beat request
- mem_ready  in  1  responder accepts beat
- mem_addr  out  64  8-byte-aligned beat address
- mem_wen  out  1  beat is a write
- mem_wdata  out  64  beat write data
- mem_wmask  out  8  byte enables; 0 for reads
- mem_rvalid  in  1  beat response (read data or write ack)
- mem_rdata  in  64  beat read data

Behaviour:
- Clock and reset: one clock, clk. Synchronous active-high reset, rst.
- Outputs: all outputs are registered. Reset values: req_ready=1; all other outputs 0. State on reset is IDLE.
- Decode at acceptance (req_valid && req_ready):
  - n = 1, 2, 4 or 8 bytes from memop[1:0]; off = addr[2:0].
  - 16-bit mask m = (n ones) << off; 128-bit data d = {64'b0, wdata} << (8*off).
  - beat0: addr={addr[63:3],3'b0}, mask m[7:0], data d[63:0].
  - beat1: beat0 addr+8, mask m[15:8], data d[127:64]. beat1 exists iff m[15:8] != 0.
  - All decode results, plus req_* fields, are latched at acceptance.
  - Address arithmetic wraps modulo 2^64.
- States: IDLE, B0_REQ, B0_RSP, B1_REQ, B1_RSP, DONE.
  - IDLE: req_ready=1. On acceptance of a no-op go to DONE; otherwise go to B0_REQ. req_ready drops the cycle after acceptance.
  - Bx_REQ: mem_valid=1, with addr/wen/wdata/wmask stable until mem_ready. mem_valid && mem_ready goes to Bx_RSP, and mem_valid drops the next cycle.
  - Bx_RSP: mem_rvalid captures mem_rdata into rbuf[x].
    - From B0_RSP: go to B1_REQ if beat1 exists, else go to DONE.
    - From B1_RSP: go to DONE.
  - DONE: resp_valid=1 for exactly one cycle, then go to IDLE.
- Load result: merged = ({rbuf1, rbuf0} >> 8*off)[63:0], with rbuf1=0 when single-beat. Extend from bit 8n-1 if memop[2]=1, else zero-extend. 8B ignores memop[2].
- Stores: the responder's mem_rdata is ignored and resp_rdata=0. A store still waits for mem_rvalid as its ack.
- Latency: zero-wait responder. Accept at T, mem_valid at T+1, mem_rvalid sampled at T+2, resp_valid at T+3. Two-beat access: resp_valid at T+5. No-op: resp_valid at T+1.
- Responder rule: mem_rvalid is ignored outside Bx_RSP. A response in the same cycle as mem_ready is not seen.
- Timeout: a per-state wait counter is cleared on each state entry and increments while waiting in Bx_REQ or Bx_RSP. When it reaches TIMEOUT-1, go to DONE with resp_err=1 and resp_rdata=0, and skip any remaining beat.
- Mid-access reset: rst forces IDLE and zeroes outputs at the next edge. Stale mem_rvalid pulses arriving later are ignored.
- req_valid held high after resp_valid: the next access is accepted the cycle after DONE.

Test Plan:
- Aligned 8B load: addr=0x80000008, memop=3'b100, mem returns 0x1122334455667788 → one beat at 0x80000008 with mask 0x00; resp_rdata=0x1122334455667788 at T+3.
- Unaligned signed word load: addr=0x80000006, memop=3'b101, beat0 data 0xABCD_0000_0000_0000, beat1 data 0x0000_0000_0000_8001 → beats at 0x80000000 then 0x80000008; merged 0x8001ABCD; resp_rdata=0xFFFFFFFF8001ABCD.
- Unaligned halfword store: addr=0x80000007, memop=3'b010, wdata=0xBEEF → beat0 mask 0x80, data 0xEF00_0000_0000_0000; beat1 mask 0x01, data 0x00000000000000BE; resp_valid after second ack.
- Byte load unsigned vs signed: addr=0x80000003, byte 0x9C → memop=3'b011 gives 0x9C; memop=3'b111 gives 0xFFFFFFFFFFFFFF9C.
- Backpressure and timeout:
  - mem_ready low for 5 cycles → mem_addr/wmask stable; completes normally.
  - With TIMEOUT=16 and mem_rvalid never asserted → resp_valid with resp_err=1 exactly 16 cycles after B0_RSP entry.
- Reset mid-access: assert rst during B1_RSP → all outputs 0 and req_ready=1 next cycle. A late mem_rvalid produces no resp_valid. No-op (memop=0, wen=0) → resp_valid at T+1, rdata 0.

Source files
------------

// File: rtl/lsu_mem_master.sv
// Load/store initiator: splits one byte/half/word/double access into one or
// two 8-byte-aligned memory beats, merges the read data and extends it.
//
// Handshakes: a pipeline request is taken when req_valid && req_ready;
// a memory beat is taken when mem_valid && mem_ready; mem_valid and the beat
// fields stay stable until taken. mem_rvalid is sampled only while waiting for
// a beat response and never in the same cycle as the beat handshake.
module lsu_mem_master #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_memop,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [63:0] mem_addr,
    output logic        mem_wen,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, B0_REQ, B0_RSP, B1_REQ, B1_RSP, DONE} state_t;
    state_t state, state_n;

    // Access fields captured at acceptance
    logic [63:0]  base_q;
    logic [2:0]   off_q;
    logic [2:0]   memop_q;
    logic         wen_q;
    logic [15:0]  mask_q;
    logic [127:0] data_q;
    logic         two_q;
    logic [63:0]  rbuf0, rbuf1;
    logic [31:0]  wait_cnt;

    // Decode of the incoming request
    logic [7:0]   ones;
    logic [15:0]  dec_mask;
    logic [127:0] dec_data;
    logic         dec_noop, accept;
    logic [63:0]  cur_base;
    logic [15:0]  cur_mask;
    logic [127:0] cur_data;
    logic         cur_wen;

    // Load merge and extension
    logic [63:0] rb0, rb1, merged, ext;

    // Next-cycle values of the registered outputs
    logic        req_ready_n, mem_valid_n, mem_wen_n, resp_valid_n, resp_err_n;
    logic [63:0] mem_addr_n, mem_wdata_n, resp_rdata_n;
    logic [7:0]  mem_wmask_n;
    logic        err_n, finish, timed_out;

    // Size decode: run of n byte enables
    always_comb begin
        case (req_memop[1:0])
            2'd3:    ones = 8'h01;
            2'd2:    ones = 8'h03;
            2'd1:    ones = 8'h0F;
            default: ones = 8'hFF;
        endcase
    end

    assign dec_mask = {8'h00, ones} << req_addr[2:0];
    assign dec_data = {64'h0, req_wdata} << {req_addr[2:0], 3'b000};
    assign dec_noop = (req_memop == 3'd0) && !req_wen;
    assign accept   = (state == IDLE) && req_valid && req_ready;

    // Beat 0 fields come straight from the decode on the acceptance cycle
    assign cur_base = accept ? {req_addr[63:3], 3'b000} : base_q;
    assign cur_mask = accept ? dec_mask : mask_q;
    assign cur_data = accept ? dec_data : data_q;
    assign cur_wen  = accept ? req_wen  : wen_q;

    // Merge read beats (the arriving beat is used directly) and extend
    always_comb begin
        rb0    = (state == B0_RSP) ? mem_rdata : rbuf0;
        rb1    = (state == B1_RSP) ? mem_rdata : rbuf1;
        merged = 64'({rb1, rb0} >> {off_q, 3'b000});
        case (memop_q[1:0])
            2'd3:    ext = memop_q[2] ? {{56{merged[7]}},  merged[7:0]}  : {56'h0, merged[7:0]};
            2'd2:    ext = memop_q[2] ? {{48{merged[15]}}, merged[15:0]} : {48'h0, merged[15:0]};
            2'd1:    ext = memop_q[2] ? {{32{merged[31]}}, merged[31:0]} : {32'h0, merged[31:0]};
            default: ext = merged;
        endcase
    end

    // Next state and next registered outputs
    always_comb begin
        state_n   = state;
        err_n     = 1'b0;
        finish    = 1'b0;
        timed_out = (wait_cnt == 32'(TIMEOUT - 1));
        case (state)
            IDLE:   if (accept) state_n = dec_noop ? DONE : B0_REQ;
            B0_REQ: begin
                if (mem_ready) state_n = B0_RSP;
                else if (timed_out) begin state_n = DONE; err_n = 1'b1; end
            end
            B0_RSP: begin
                if (mem_rvalid) begin
                    state_n = two_q ? B1_REQ : DONE;
                    finish  = !two_q;
                end else if (timed_out) begin state_n = DONE; err_n = 1'b1; end
            end
            B1_REQ: begin
                if (mem_ready) state_n = B1_RSP;
                else if (timed_out) begin state_n = DONE; err_n = 1'b1; end
            end
            B1_RSP: begin
                if (mem_rvalid) begin state_n = DONE; finish = 1'b1; end
                else if (timed_out) begin state_n = DONE; err_n = 1'b1; end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        req_ready_n  = (state_n == IDLE);
        mem_valid_n  = 1'b0;
        mem_addr_n   = 64'h0;
        mem_wen_n    = 1'b0;
        mem_wdata_n  = 64'h0;
        mem_wmask_n  = 8'h00;
        if (state_n == B0_REQ) begin
            mem_valid_n = 1'b1;
            mem_addr_n  = cur_base;
            mem_wen_n   = cur_wen;
            mem_wdata_n = cur_wen ? cur_data[63:0] : 64'h0;
            mem_wmask_n = cur_wen ? cur_mask[7:0] : 8'h00;
        end else if (state_n == B1_REQ) begin
            mem_valid_n = 1'b1;
            mem_addr_n  = base_q + 64'd8;
            mem_wen_n   = wen_q;
            mem_wdata_n = wen_q ? data_q[127:64] : 64'h0;
            mem_wmask_n = wen_q ? mask_q[15:8] : 8'h00;
        end
        resp_valid_n = (state_n == DONE);
        resp_err_n   = err_n;
        resp_rdata_n = (finish && !wen_q) ? ext : 64'h0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready  <= 1'b1;
            mem_valid  <= 1'b0;
            mem_addr   <= 64'h0;
            mem_wen    <= 1'b0;
            mem_wdata  <= 64'h0;
            mem_wmask  <= 8'h00;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 64'h0;
        end else begin
            req_ready  <= req_ready_n;
            mem_valid  <= mem_valid_n;
            mem_addr   <= mem_addr_n;
            mem_wen    <= mem_wen_n;
            mem_wdata  <= mem_wdata_n;
            mem_wmask  <= mem_wmask_n;
            resp_valid <= resp_valid_n;
            resp_err   <= resp_err_n;
            resp_rdata <= resp_rdata_n;
        end
    end

    // Access latch, read buffers and per-state wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q   <= 64'h0;
            off_q    <= 3'd0;
            memop_q  <= 3'd0;
            wen_q    <= 1'b0;
            mask_q   <= 16'h0;
            data_q   <= 128'h0;
            two_q    <= 1'b0;
            rbuf0    <= 64'h0;
            rbuf1    <= 64'h0;
            wait_cnt <= 32'd0;
        end else begin
            if (accept) begin
                base_q  <= {req_addr[63:3], 3'b000};
                off_q   <= req_addr[2:0];
                memop_q <= req_memop;
                wen_q   <= req_wen;
                mask_q  <= dec_mask;
                data_q  <= dec_data;
                two_q   <= (dec_mask[15:8] != 8'h00);
                rbuf0   <= 64'h0;
                rbuf1   <= 64'h0;
            end
            if (state == B0_RSP && mem_rvalid) rbuf0 <= mem_rdata;
            if (state == B1_RSP && mem_rvalid) rbuf1 <= mem_rdata;
            if (state_n != state || state == IDLE || state == DONE) wait_cnt <= 32'd0;
            else                                                    wait_cnt <= wait_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed accesses against a byte-addressed
// memory model, with a scoreboard of expected beats and completions.
module tb_lsu_mem_master;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [2:0]  req_memop;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  lsu_mem_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_memop(req_memop), .req_wen(req_wen), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  longint cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [7:0] mem_bytes [logic [63:0]];

  function automatic logic [7:0] rd_byte(input logic [63:0] a);
    return mem_bytes.exists(a) ? mem_bytes[a] : 8'h00;
  endfunction

  task automatic put_bytes(input logic [63:0] a, input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) mem_bytes[a + 64'(i)] = v[8*i +: 8];
  endtask

  function automatic int msize(input logic [2:0] op);
    return (op[1:0] == 2'd3) ? 1 : (op[1:0] == 2'd2) ? 2 : (op[1:0] == 2'd1) ? 4 : 8;
  endfunction

  // Expected load value: n bytes at consecutive addresses, then extension
  function automatic logic [63:0] model_load(input logic [63:0] a, input logic [2:0] op);
    int n = msize(op);
    logic [63:0] v = 64'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd_byte(a + 64'(i));
    if (op[2] && n < 8 && v[8*n-1])
      for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Expected beat k: which of its 8 bytes fall inside [a, a+n), and their data
  task automatic model_beat(input logic [63:0] a, input int n, input logic [63:0] wd, input int k,
                            output logic [63:0] baddr, output logic [7:0] mask, output logic [63:0] data);
    logic [63:0] idx;
    baddr = {a[63:3], 3'b000} + 64'(8*k);
    mask = 8'h00;
    data = 64'h0;
    for (int j = 0; j < 8; j++) begin
      idx = baddr + 64'(j) - a;
      if (idx < 64'(n)) begin
        mask[j] = 1'b1;
        data[8*j +: 8] = wd[8*int'(idx[2:0]) +: 8];
      end
    end
  endtask

  // ---------------- scoreboard queues ----------------
  logic [63:0] exp_addr_q[$];
  logic [7:0]  exp_mask_q[$];
  logic [63:0] exp_data_q[$];
  logic        exp_wen_q[$];
  logic [63:0] exp_rdata_q[$];
  logic        exp_err_q[$];
  longint      exp_cyc_q[$];
  int          resp_seen = 0;

  // ---------------- responder ----------------
  int   rd_delay = 0, rsp_delay = 0;
  bit   rsp_never = 0, ready_never = 0;
  bit   rsp_pend = 0;
  int   rsp_cnt = 0, vcnt = 0;
  logic [63:0] rsp_addr;
  logic        rsp_wen;

  initial begin
    logic        hs, hs_wen;
    logic [63:0] hs_addr, hs_wdata;
    logic [7:0]  hs_mask;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h0;
    forever begin
      @(negedge clk);
      hs = mem_valid && mem_ready && !rst;
      hs_addr = mem_addr; hs_wen = mem_wen; hs_mask = mem_wmask; hs_wdata = mem_wdata;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = 64'h0;
      if (hs) begin
        if (hs_wen)
          for (int j = 0; j < 8; j++)
            if (hs_mask[j]) mem_bytes[hs_addr + 64'(j)] = hs_wdata[8*j +: 8];
        rsp_pend = 1; rsp_cnt = rsp_delay; rsp_addr = hs_addr; rsp_wen = hs_wen;
      end
      if (rsp_pend && !rsp_never) begin
        if (rsp_cnt == 0) begin
          mem_rvalid = 1'b1;
          if (rsp_wen) mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
          else for (int j = 0; j < 8; j++) mem_rdata[8*j +: 8] = rd_byte(rsp_addr + 64'(j));
          rsp_pend = 0;
        end else rsp_cnt--;
      end
      if (mem_valid && !ready_never) begin
        mem_ready = (vcnt >= rd_delay);
        vcnt++;
      end else begin
        mem_ready = 1'b0;
        vcnt = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  logic        prev_wait = 1'b0;
  logic [63:0] prev_addr;
  logic [7:0]  prev_mask;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_wait && mem_valid) begin
        check("beat_addr_stable", mem_addr, prev_addr);
        check("beat_mask_stable", {56'h0, mem_wmask}, {56'h0, prev_mask});
      end
      prev_wait = mem_valid && !mem_ready;
      prev_addr = mem_addr;
      prev_mask = mem_wmask;
      if (mem_valid && mem_ready) begin
        if (exp_addr_q.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
        else begin
          logic w;
          w = exp_wen_q.pop_front();
          check("beat_addr", mem_addr, exp_addr_q.pop_front());
          check("beat_wmask", {56'h0, mem_wmask}, {56'h0, exp_mask_q.pop_front()});
          check("beat_wen", {63'h0, mem_wen}, {63'h0, w});
          if (w) check("beat_wdata", mem_wdata, exp_data_q.pop_front());
          else void'(exp_data_q.pop_front());
        end
      end
      if (resp_valid) begin
        resp_seen++;
        if (exp_rdata_q.size() == 0) check("unexpected_resp", 64'd1, 64'd0);
        else begin
          check("resp_rdata", resp_rdata, exp_rdata_q.pop_front());
          check("resp_err", {63'h0, resp_err}, {63'h0, exp_err_q.pop_front()});
          check("resp_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // mode 0: normal, 1: responder never answers, 2: responder never ready
  task automatic access(input logic [63:0] a, input logic [2:0] op, input logic w,
                        input logic [63:0] wd, input int rd, input int sd, input int mode,
                        output logic [63:0] got);
    int n, nb, pb;
    bit noop, fin;
    longint t;
    logic [63:0] ba, bd;
    logic [7:0]  bm;
    rd_delay = rd; rsp_delay = sd; rsp_never = (mode == 1); ready_never = (mode == 2);
    @(posedge clk); #1;
    req_addr = a; req_memop = op; req_wen = w; req_wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    check("req_ready_idle", {63'h0, req_ready}, 64'd1);
    t = cyc;
    n = msize(op);
    noop = (op == 3'd0) && !w;
    nb = noop ? 0 : ((int'(a[2:0]) + n > 8) ? 2 : 1);
    pb = (mode == 2) ? 0 : (mode == 1) ? 1 : nb;
    for (int k = 0; k < pb; k++) begin
      model_beat(a, n, wd, k, ba, bm, bd);
      exp_addr_q.push_back(ba);
      exp_mask_q.push_back(w ? bm : 8'h00);
      exp_data_q.push_back(bd);
      exp_wen_q.push_back(w);
    end
    exp_rdata_q.push_back((mode != 0 || w || noop) ? 64'h0 : model_load(a, op));
    exp_err_q.push_back(mode != 0);
    exp_cyc_q.push_back((mode == 1) ? t + 2 + rd + TO :
                        (mode == 2) ? t + 1 + TO : t + 1 + nb * (2 + rd + sd));
    fin = 0;
    got = 64'h0;
    for (int i = 0; i < 200 && !fin; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        fin = 1; got = resp_rdata; req_valid = 1'b0;
      end else if (i == 0) check("req_ready_busy", {63'h0, req_ready}, 64'd0);
    end
    if (!fin) begin
      check("resp_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
    end
    @(negedge clk);
    check("req_ready_after", {63'h0, req_ready}, 64'd1);
    rsp_pend = 0; rsp_never = 0; ready_never = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] got, ba, bd;
    logic [7:0]  bm;
    longint t;
    int seen0;
    rst = 1'b1; req_valid = 1'b0; req_addr = 64'h0; req_memop = 3'd0;
    req_wen = 1'b0; req_wdata = 64'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {63'h0, req_ready}, 64'd1);
    check("rst_mem_valid", {63'h0, mem_valid}, 64'd0);
    check("rst_resp_valid", {63'h0, resp_valid}, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'h0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_mem_wmask", {56'h0, mem_wmask}, 64'h0);

    // Aligned 8B load
    put_bytes(64'h8000_0008, 64'h1122_3344_5566_7788, 8);
    check("model_load_8b", model_load(64'h8000_0008, 3'b100), 64'h1122_3344_5566_7788);
    access(64'h8000_0008, 3'b100, 1'b0, 64'h0, 0, 0, 0, got);
    check("load_8b", got, 64'h1122_3344_5566_7788);

    // Unaligned signed word load across two beats
    put_bytes(64'h8000_0006, 64'h8001_ABCD, 4);
    check("model_load_sw", model_load(64'h8000_0006, 3'b101), 64'hFFFF_FFFF_8001_ABCD);
    access(64'h8000_0006, 3'b101, 1'b0, 64'h0, 0, 0, 0, got);
    check("load_sw_unaligned", got, 64'hFFFF_FFFF_8001_ABCD);

    // Unaligned halfword store
    model_beat(64'h8000_0007, 2, 64'hBEEF, 0, ba, bm, bd);
    check("model_b0_mask", {56'h0, bm}, 64'h80);
    check("model_b0_data", bd, 64'hEF00_0000_0000_0000);
    model_beat(64'h8000_0007, 2, 64'hBEEF, 1, ba, bm, bd);
    check("model_b1_addr", ba, 64'h8000_0008);
    check("model_b1_data", bd, 64'h0000_0000_0000_00BE);
    access(64'h8000_0007, 3'b010, 1'b1, 64'hBEEF, 0, 0, 0, got);
    check("store_h_rdata", got, 64'h0);
    check("store_h_byte7", {56'h0, rd_byte(64'h8000_0007)}, 64'hEF);
    check("store_h_byte8", {56'h0, rd_byte(64'h8000_0008)}, 64'hBE);
    check("store_h_byte6", {56'h0, rd_byte(64'h8000_0006)}, 64'hCD);

    // Byte load unsigned / signed
    put_bytes(64'h8000_0003, 64'h9C, 1);
    access(64'h8000_0003, 3'b011, 1'b0, 64'h0, 0, 0, 0, got);
    check("load_bu", got, 64'h9C);
    access(64'h8000_0003, 3'b111, 1'b0, 64'h0, 0, 0, 0, got);
    check("load_bs", got, 64'hFFFF_FFFF_FFFF_FF9C);

    // Backpressure on request and delayed response, two beats
    put_bytes(64'h8000_0017, 64'h8123, 2);
    access(64'h8000_0017, 3'b110, 1'b0, 64'h0, 5, 3, 0, got);
    check("load_hs_backpressure", got, 64'hFFFF_FFFF_FFFF_8123);

    // Unaligned 8B store, then reload it
    access(64'h8000_0025, 3'b000, 1'b1, 64'h0102_0304_0506_0708, 1, 2, 0, got);
    check("store_d_first", {56'h0, rd_byte(64'h8000_0025)}, 64'h08);
    check("store_d_last", {56'h0, rd_byte(64'h8000_002C)}, 64'h01);
    access(64'h8000_0025, 3'b100, 1'b0, 64'h0, 0, 0, 0, got);
    check("reload_d", got, 64'h0102_0304_0506_0708);

    // Address wrap at the top of the address space
    put_bytes(64'hFFFF_FFFF_FFFF_FFFE, 64'h89AB_CDEF, 4);
    access(64'hFFFF_FFFF_FFFF_FFFE, 3'b001, 1'b0, 64'h0, 0, 0, 0, got);
    check("load_wrap", got, 64'h0000_0000_89AB_CDEF);

    // Timeouts: no response, then no ready
    access(64'h8000_0008, 3'b100, 1'b0, 64'h0, 2, 0, 1, got);
    check("timeout_rsp_rdata", got, 64'h0);
    access(64'h8000_0008, 3'b100, 1'b0, 64'h0, 0, 0, 2, got);
    check("timeout_req_rdata", got, 64'h0);

    // No-op
    access(64'h8000_0040, 3'b000, 1'b0, 64'h0, 0, 0, 0, got);
    check("noop_rdata", got, 64'h0);

    // Back-to-back no-ops with req_valid held high
    @(posedge clk); #1;
    req_addr = 64'h0; req_memop = 3'd0; req_wen = 1'b0; req_valid = 1'b1;
    t = cyc;
    exp_rdata_q.push_back(64'h0); exp_err_q.push_back(1'b0); exp_cyc_q.push_back(t + 1);
    exp_rdata_q.push_back(64'h0); exp_err_q.push_back(1'b0); exp_cyc_q.push_back(t + 3);
    repeat (4) @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_drained", 64'(exp_cyc_q.size()), 64'd0);

    // Reset during B1_RSP, then a stale response
    put_bytes(64'h8000_0046, 64'h1234_5678, 4);
    rd_delay = 0; rsp_delay = 4;
    @(posedge clk); #1;
    req_addr = 64'h8000_0046; req_memop = 3'b001; req_wen = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    t = cyc;
    for (int k = 0; k < 2; k++) begin
      model_beat(64'h8000_0046, 4, 64'h0, k, ba, bm, bd);
      exp_addr_q.push_back(ba); exp_mask_q.push_back(8'h00);
      exp_data_q.push_back(bd); exp_wen_q.push_back(1'b0);
    end
    for (int i = 0; i < 50 && cyc < t + 9; i++) @(posedge clk);
    #1 rst = 1'b1; req_valid = 1'b0;
    seen0 = resp_seen;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", {63'h0, req_ready}, 64'd1);
    check("midrst_mem_valid", {63'h0, mem_valid}, 64'd0);
    check("midrst_resp_valid", {63'h0, resp_valid}, 64'd0);
    check("midrst_mem_addr", mem_addr, 64'h0);
    repeat (10) @(negedge clk);
    check("midrst_no_resp", 64'(resp_seen - seen0), 64'd0);
    rsp_delay = 0;

    check("queues_empty", 64'(exp_addr_q.size() + exp_rdata_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
